// File: rtl/tff_mod_counter.sv
// Modulo-N up/down counter built from behavioural T flip-flops.
// Ports: clk, clear (async reset), enable, up_dn, load, load_val -> q, tc, wrap, load_err.
module tff_mod_counter #(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 256
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  // One extra bit so MODULUS == 2**WIDTH is representable.
  localparam logic [WIDTH:0]   MOD = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] t;
  logic             nxt_wrap;
  logic             nxt_err;
  logic             at_top;
  logic             at_zero;
  logic             out_rng;
  logic             ld_ok;

  assign at_top  = (q == TOP);
  assign at_zero = (q == '0);
  assign out_rng = ({1'b0, q} >= MOD);
  assign ld_ok   = ({1'b0, load_val} < MOD);

  // Priority: load, then count, then hold.
  always_comb begin
    nxt      = q;
    nxt_wrap = 1'b0;
    nxt_err  = 1'b0;
    if (load) begin
      if (ld_ok) begin
        nxt = load_val;
      end else begin
        nxt_err = 1'b1;
      end
    end else if (enable) begin
      if (up_dn) begin
        if (at_top) begin
          nxt      = '0;
          nxt_wrap = 1'b1;
        end else if (out_rng) begin
          nxt = '0;
        end else begin
          nxt = q + ONE;
        end
      end else begin
        if (at_zero) begin
          nxt      = TOP;
          nxt_wrap = 1'b1;
        end else if (out_rng) begin
          nxt = TOP;
        end else begin
          nxt = q - ONE;
        end
      end
    end
  end

  // Toggle inputs: a bit flips exactly where next differs from now.
  assign t = q ^ nxt;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (t[i]) q[i] <= ~q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= nxt_wrap;
      load_err <= nxt_err;
    end
  end

  // Unregistered so it can chain into the next stage's enable.
  assign tc = enable & ((up_dn & at_top) | (~up_dn & at_zero));

endmodule
